// File: rtl/cv32e40px_wb_arbiter_if.sv
// Write-back arbiter bus: EX / LSU / APU result sources in, two register
// file write ports plus APU FIFO status out.
//   slave  : seen by the arbiter (sources in, write ports out)
//   master : seen by whatever drives the sources and observes the ports
interface cv32e40px_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int APU_DEPTH  = 2
);
  localparam int PEND_W = $clog2(APU_DEPTH + 1);

  logic                  ex_valid_i;
  logic [ADDR_WIDTH-1:0] ex_waddr_i;
  logic [DATA_WIDTH-1:0] ex_wdata_i;
  logic                  lsu_valid_i;
  logic [ADDR_WIDTH-1:0] lsu_waddr_i;
  logic [DATA_WIDTH-1:0] lsu_wdata_i;
  logic                  apu_valid_i;
  logic                  apu_ready_o;
  logic [ADDR_WIDTH-1:0] apu_waddr_i;
  logic [DATA_WIDTH-1:0] apu_wdata_i;
  logic [ADDR_WIDTH-1:0] waddr_a_o;
  logic [DATA_WIDTH-1:0] wdata_a_o;
  logic                  we_a_o;
  logic [ADDR_WIDTH-1:0] waddr_b_o;
  logic [DATA_WIDTH-1:0] wdata_b_o;
  logic                  we_b_o;
  logic [PEND_W-1:0]     apu_pending_o;
  logic                  collision_o;

  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  apu_valid_i, apu_waddr_i, apu_wdata_i,
    output apu_ready_o,
    output waddr_a_o, wdata_a_o, we_a_o,
    output waddr_b_o, wdata_b_o, we_b_o,
    output apu_pending_o, collision_o
  );

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output apu_valid_i, apu_waddr_i, apu_wdata_i,
    input  apu_ready_o,
    input  waddr_a_o, wdata_a_o, we_a_o,
    input  waddr_b_o, wdata_b_o, we_b_o,
    input  apu_pending_o, collision_o
  );
endinterface

// File: rtl/cv32e40px_wb_arbiter.sv
// Write-back arbiter feeding register file ports A (W1) and B (W2).
//   EX results  -> port A, LSU results -> port B, one registered cycle.
//   APU results -> APU_DEPTH-entry FIFO, drained into idle ports.
// Ports: clk, rst_n (synchronous, active low), bus (slave modport):
//   ex_*/lsu_* direct sources (always accepted), apu_* valid/ready source,
//   waddr/wdata/we_{a,b}_o write ports, apu_pending_o FIFO occupancy,
//   collision_o pulse when a drained APU entry loses to a direct write.
module cv32e40px_wb_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int APU_DEPTH  = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  cv32e40px_wb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(APU_DEPTH + 1);
  localparam int PTR_W = (APU_DEPTH > 1) ? $clog2(APU_DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } apu_entry_t;

  apu_entry_t            fifo_q [APU_DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q, head_p1;
  logic [CNT_W-1:0]      count_q;

  logic                  ready, push;
  logic                  ex_wr, lsu_wr;
  logic                  cand_a, cand_b, coll_a, coll_b, apu_wr_a, apu_wr_b;
  apu_entry_t            ent_a, ent_b;
  logic [1:0]            pops;

  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;
  logic                  we_a_q, we_b_q, coll_q;

  // Modulo increment so non power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(APU_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A drained entry collides with a nonzero direct write to the same register.
  function automatic logic direct_hit(input logic [ADDR_WIDTH-1:0] a);
    return (ex_wr && (a == bus.ex_waddr_i)) || (lsu_wr && (a == bus.lsu_waddr_i));
  endfunction

  // Ready depends on the registered count only, never on apu_valid_i.
  assign ready = (count_q < CNT_W'(APU_DEPTH));
  assign push  = bus.apu_valid_i && ready;

  always_comb begin
    head_p1 = ptr_inc(head_q);
    ex_wr   = bus.ex_valid_i  && (bus.ex_waddr_i  != '0);
    lsu_wr  = bus.lsu_valid_i && (bus.lsu_waddr_i != '0);
    // Head always goes to A when A is idle; B takes head+1 if A also drains,
    // otherwise the head itself.
    cand_a  = !bus.ex_valid_i && (count_q != '0);
    cand_b  = !bus.lsu_valid_i &&
              (bus.ex_valid_i ? (count_q != '0) : (count_q > CNT_W'(1)));
    ent_a   = fifo_q[head_q];
    ent_b   = bus.ex_valid_i ? fifo_q[head_q] : fifo_q[head_p1];
    coll_a  = cand_a && direct_hit(ent_a.addr);
    coll_b  = cand_b && direct_hit(ent_b.addr);
    // x0 entries and collided entries are popped without a write.
    apu_wr_a = cand_a && (ent_a.addr != '0) && !coll_a;
    apu_wr_b = cand_b && (ent_b.addr != '0) && !coll_b;
    pops     = {1'b0, cand_a} + {1'b0, cand_b};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_a_q <= '0;
      waddr_b_q <= '0;
      wdata_a_q <= '0;
      wdata_b_q <= '0;
      coll_q    <= 1'b0;
    end else begin
      if (push) tail_q <= ptr_inc(tail_q);
      case (pops)
        2'd1:    head_q <= head_p1;
        2'd2:    head_q <= ptr_inc(head_p1);
        default: head_q <= head_q;
      endcase
      count_q <= count_q + CNT_W'(push) - CNT_W'(pops);

      we_a_q <= ex_wr || apu_wr_a;
      if (ex_wr) begin
        waddr_a_q <= bus.ex_waddr_i;
        wdata_a_q <= bus.ex_wdata_i;
      end else if (apu_wr_a) begin
        waddr_a_q <= ent_a.addr;
        wdata_a_q <= ent_a.data;
      end

      we_b_q <= lsu_wr || apu_wr_b;
      if (lsu_wr) begin
        waddr_b_q <= bus.lsu_waddr_i;
        wdata_b_q <= bus.lsu_wdata_i;
      end else if (apu_wr_b) begin
        waddr_b_q <= ent_b.addr;
        wdata_b_q <= ent_b.data;
      end

      coll_q <= coll_a || coll_b;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= '{addr: bus.apu_waddr_i, data: bus.apu_wdata_i};
  end

  assign bus.apu_ready_o   = ready;
  assign bus.apu_pending_o = count_q;
  assign bus.waddr_a_o     = waddr_a_q;
  assign bus.wdata_a_o     = wdata_a_q;
  assign bus.we_a_o        = we_a_q;
  assign bus.waddr_b_o     = waddr_b_q;
  assign bus.wdata_b_o     = wdata_b_q;
  assign bus.we_b_o        = we_b_q;
  assign bus.collision_o   = coll_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(APU_DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> ready);
endmodule

// File: tb/tb_cv32e40px_wb_arbiter.sv
module tb_cv32e40px_wb_arbiter;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cv32e40px_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APU_DEPTH(DEPTH)) bus ();

  cv32e40px_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APU_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model: APU results held as a plain ordered queue.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit exv, input logic [AW-1:0] exa, input logic [DW-1:0] exd,
                       input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    bus.ex_valid_i  = exv; bus.ex_waddr_i  = exa; bus.ex_wdata_i  = exd;
    bus.lsu_valid_i = lv;  bus.lsu_waddr_i = la;  bus.lsu_wdata_i = ld;
    bus.apu_valid_i = av;  bus.apu_waddr_i = aa;  bus.apu_wdata_i = ad;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: predict from current inputs and queue, advance, compare.
  task automatic step();
    bit            exv, lv, push;
    logic [AW-1:0] exa, la, ea, eb;
    logic [DW-1:0] da, db;
    bit            we_a, we_b, coll;
    bit            to_b [2];
    int            nd;
    ent_t          e;
    exv = bus.ex_valid_i;  exa = bus.ex_waddr_i;
    lv  = bus.lsu_valid_i; la  = bus.lsu_waddr_i;
    we_a = 0; we_b = 0; coll = 0; ea = 0; eb = 0; da = 0; db = 0; nd = 0;
    to_b[0] = 0; to_b[1] = 1;
    chk("apu_ready", {63'd0, bus.apu_ready_o}, {63'd0, q.size() < DEPTH});
    push = bus.apu_valid_i && (q.size() < DEPTH) && rst_n;
    if (rst_n) begin
      if (exv && exa != 0) begin we_a = 1; ea = exa; da = bus.ex_wdata_i; end
      if (lv && la != 0)   begin we_b = 1; eb = la;  db = bus.lsu_wdata_i; end
      if (!exv && !lv) nd = (q.size() >= 2) ? 2 : q.size();
      else if (!exv || !lv) begin
        nd = (q.size() >= 1) ? 1 : 0;
        to_b[0] = exv;
      end
      for (int k = 0; k < nd; k++) begin
        e = q[k];
        if (e.a == 0) begin end
        else if ((exv && exa == e.a) || (lv && la == e.a)) coll = 1;
        else if (to_b[k]) begin we_b = 1; eb = e.a; db = e.d; end
        else begin we_a = 1; ea = e.a; da = e.d; end
      end
      repeat (nd) void'(q.pop_front());
      if (push) q.push_back('{bus.apu_waddr_i, bus.apu_wdata_i});
    end else begin
      q.delete();
    end
    @(posedge clk);
    #1;
    chk("we_a", {63'd0, bus.we_a_o}, {63'd0, we_a});
    chk("we_b", {63'd0, bus.we_b_o}, {63'd0, we_b});
    chk("collision", {63'd0, bus.collision_o}, {63'd0, coll});
    chk("apu_pending", 64'(bus.apu_pending_o), 64'(q.size()));
    if (we_a) begin
      chk("waddr_a", 64'(bus.waddr_a_o), 64'(ea));
      chk("wdata_a", 64'(bus.wdata_a_o), 64'(da));
    end
    if (we_b) begin
      chk("waddr_b", 64'(bus.waddr_b_o), 64'(eb));
      chk("wdata_b", 64'(bus.wdata_b_o), 64'(db));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] addr_set [7];
    addr_set = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd7, 6'd33, 6'd34};
    idle();

    // Reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_we_a", {63'd0, bus.we_a_o}, 64'd0);
    chk("rst_we_b", {63'd0, bus.we_b_o}, 64'd0);
    chk("rst_coll", {63'd0, bus.collision_o}, 64'd0);
    chk("rst_pending", 64'(bus.apu_pending_o), 64'd0);
    chk("rst_ready", {63'd0, bus.apu_ready_o}, 64'd1);
    rst_n = 1'b1;

    // EX direct write to port A
    repeat (3) step();
    drive(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    step();
    chk("t1_we_a", {63'd0, bus.we_a_o}, 64'd1);
    chk("t1_waddr_a", 64'(bus.waddr_a_o), 64'd3);
    chk("t1_wdata_a", 64'(bus.wdata_a_o), 64'hDEADBEEF);
    chk("t1_we_b", {63'd0, bus.we_b_o}, 64'd0);
    idle(); step();

    // Single APU result drains to A two cycles after handshake
    drive(0, 0, 0, 0, 0, 0, 1, 33, 32'h3F800000);
    step();
    chk("t2_pending1", 64'(bus.apu_pending_o), 64'd1);
    idle(); step();
    chk("t2_we_a", {63'd0, bus.we_a_o}, 64'd1);
    chk("t2_waddr_a", 64'(bus.waddr_a_o), 64'd33);
    chk("t2_wdata_a", 64'(bus.wdata_a_o), 64'h3F800000);
    chk("t2_pending0", 64'(bus.apu_pending_o), 64'd0);

    // Two same-address entries drain together: A older, B newer
    drive(1, 10, 32'h10, 1, 11, 32'h11, 1, 5, 32'h1); step();
    drive(1, 10, 32'h12, 1, 11, 32'h13, 1, 5, 32'h2); step();
    chk("t3_ready_full", {63'd0, bus.apu_ready_o}, 64'd0);
    drive(1, 10, 32'h14, 1, 11, 32'h15, 0, 0, 0); step();
    chk("t3_pending2", 64'(bus.apu_pending_o), 64'd2);
    idle(); step();
    chk("t3_a_data", 64'(bus.wdata_a_o), 64'h1);
    chk("t3_b_data", 64'(bus.wdata_b_o), 64'h2);
    chk("t3_b_addr", 64'(bus.waddr_b_o), 64'd5);
    chk("t3_ready_back", {63'd0, bus.apu_ready_o}, 64'd1);

    // Collision: head 7 headed for B while EX writes 7
    drive(1, 10, 32'h20, 1, 11, 32'h21, 1, 7, 32'h77); step();
    drive(1, 7, 32'hAA, 0, 0, 0, 0, 0, 0); step();
    chk("t4_wdata_a", 64'(bus.wdata_a_o), 64'hAA);
    chk("t4_we_b", {63'd0, bus.we_b_o}, 64'd0);
    chk("t4_coll", {63'd0, bus.collision_o}, 64'd1);
    chk("t4_pending", 64'(bus.apu_pending_o), 64'd0);

    // x0 writes dropped from every source
    drive(1, 0, 32'h55, 0, 0, 0, 1, 0, 32'h66); step();
    chk("t5_we_a_ex", {63'd0, bus.we_a_o}, 64'd0);
    idle(); step();
    chk("t5_we_a_apu", {63'd0, bus.we_a_o}, 64'd0);
    chk("t5_pending", 64'(bus.apu_pending_o), 64'd0);

    // Reset with a full FIFO: no stale entry may appear afterwards
    drive(1, 10, 32'h30, 1, 11, 32'h31, 1, 9, 32'h99); step();
    drive(1, 10, 32'h32, 1, 11, 32'h33, 1, 12, 32'hCC); step();
    idle(); rst_n = 1'b0; step();
    chk("t6_pending", 64'(bus.apu_pending_o), 64'd0);
    chk("t6_ready", {63'd0, bus.apu_ready_o}, 64'd1);
    chk("t6_we_a", {63'd0, bus.we_a_o}, 64'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1) == 1, addr_set[$urandom_range(0, 6)], $urandom(),
            $urandom_range(0, 1) == 1, addr_set[$urandom_range(0, 6)], $urandom(),
            $urandom_range(0, 2) != 0, addr_set[$urandom_range(0, 6)], $urandom());
      rst_n = ($urandom_range(0, 255) != 0);
      step();
    end
    rst_n = 1'b1;
    idle();
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
